zap_shifter_divide: RTL and testbench
=====================================

# zap_shifter_divide

Sequential 32÷32 integer divider for the execute stage, sitting beside the shifter/multiply unit and sharing its stall/clear discipline. Accepts signed or unsigned SDIV/UDIV-style operations, computes quotient and remainder by a one-bit-per-cycle restoring algorithm, and presents a registered result with a one-cycle valid pulse. The ALU holds `o_busy`-stalled operations in place until the result returns.

## Interface
- `DIV_ZERO_VALUE`, 32'd0, quotient returned when divisor is zero.
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_clear_from_writeback`  in  1  pipeline flush; abort to IDLE.
- `i_data_stall`  in  1  hold all state.
- `i_clear_from_alu`  in  1  ALU flush; abort to IDLE.
- `i_start`  in  1  request a division; honoured only in IDLE.
- `i_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `i_rn`  in  32  dividend.
- `i_rm`  in  32  divisor.
- `o_rd`  out  32  quotient, registered.
- `o_rem`  out  32  remainder, registered.
- `o_busy`  out  1  unit busy; the ALU must hold its operation.
- `o_valid`  out  1  result valid in `o_rd`/`o_rem`.
- `o_div_zero`  out  1  qualifies `o_valid`; divisor was zero.

## Operation
- Reset values: state IDLE, `o_rd`=0, `o_rem`=0, `o_valid`=0, `o_div_zero`=0, `o_busy`=0, counter 0.
- State update priority, highest first: reset > `i_clear_from_writeback` > `i_data_stall` > `i_clear_from_alu` > normal advance.
- States:
  - IDLE → PREP on `i_start`.
  - PREP → CALC normally; PREP → DONE on divisor==0.
  - CALC → FIX after 32 iterations.
  - FIX → DONE.
  - DONE → IDLE.
- IDLE: `o_busy` = `i_start` (combinational). On accept, latch `i_rn`, `i_rm` and `i_signed`.
- PREP:
  - Record `neg_q` = signed & (rn[31]^rm[31]) and `neg_r` = signed & rn[31].
  - Replace each operand by its magnitude (unsigned 32-bit; 0x80000000 stays 0x80000000).
  - Clear the 33-bit partial remainder; load the quotient shift register with |rn|; set counter = 31.
  - Divisor zero: register `o_rd`=`DIV_ZERO_VALUE`, `o_rem`=original dividend, `o_div_zero`=1.
- CALC, each cycle:
  - trial = {rem[31:0], q[31]} − {1'b0, |rm|}.
  - trial[32]==0: rem=trial, q={q[30:0],1}. Otherwise: rem={rem[31:0],q[31]}, q={q[30:0],0}.
  - Decrement the counter; leave CALC after the cycle where the counter was 0.
- FIX:
  - `o_rd` = `neg_q` ? −q : q; `o_rem` = `neg_r` ? −rem[31:0] : rem[31:0]; `o_div_zero`=0.
  - Quotient truncates toward zero. 0x80000000 ÷ −1 (signed) yields 0x80000000, remainder 0; no trap or flag.
- DONE: `o_valid`=1, `o_busy`=0. `o_rd`/`o_rem` hold until the next FIX or PREP-with-zero.
- `o_busy`=1 in PREP, CALC and FIX.
- Clear in any state: next state IDLE; `o_valid` low next cycle; `o_rd`/`o_rem` not modified; in-flight result discarded.
- Stall in any state: counter, registers and state frozen. In DONE, `o_valid` stays high for the whole stall.
- `i_start` outside IDLE is ignored.
- Asynchronous reset mid-operation returns everything to reset values immediately.

## Timing
- Accept edge = cycle 0 (IDLE with `i_start`). Cycle numbers count stall-free cycles.
- Normal division: PREP cycle 1, CALC cycles 2–33, FIX cycle 34, DONE/`o_valid` cycle 35. Latency is 35 cycles, independent of operand values.
- Divide by zero: PREP cycle 1, DONE/`o_valid` cycle 2.
- Each stall cycle adds exactly one cycle to the latency.
- Back-to-back: a new `i_start` is accepted in the IDLE cycle after DONE, earliest cycle 36.
- Operands may change after cycle 0 without effect.

## Test plan
- Unsigned 100 ÷ 7, start at cycle 0 → `o_valid` cycle 35 only, `o_rd`=14, `o_rem`=2, `o_busy` high cycles 0–34.
- Signed −7 ÷ 2 → `o_rd`=0xFFFFFFFD, `o_rem`=0xFFFFFFFF. Unsigned 0xFFFFFFFF ÷ 0x10 → 0x0FFFFFFF, rem 0xF.
- Signed 0x80000000 ÷ 0xFFFFFFFF → `o_rd`=0x80000000, `o_rem`=0. Unsigned 0x80000000 ÷ 1 → 0x80000000, rem 0.
- Divide by zero (rn=0x1234, rm=0) → `o_valid` at cycle 2, `o_div_zero`=1, `o_rd`=`DIV_ZERO_VALUE`, `o_rem`=0x1234.
- `i_data_stall` for 5 cycles during CALC → `o_valid` at cycle 40, result correct. Stall during DONE → `o_valid` held for the stall length.
- Each of the following, asserted at cycle 10 of a division, returns the unit to IDLE with no `o_valid`; a following start then computes correctly:
  - `i_clear_from_alu`;
  - `i_clear_from_writeback`;
  - asynchronous `i_reset_n` low (outputs must show reset values with no clock edge).

Source files
------------

// File: rtl/zap_shifter_divide.sv
// zap_shifter_divide: sequential 32/32 restoring divider for the execute
// stage. One quotient bit per cycle; signed operands are handled by dividing
// magnitudes and fixing signs at the end. Fixed latency of 35 cycles, or 2
// cycles for a zero divisor.
module zap_shifter_divide #(
  parameter logic [31:0] DIV_ZERO_VALUE = 32'd0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_start,
  input  logic        i_signed,
  input  logic [31:0] i_rn,
  input  logic [31:0] i_rm,
  output logic [31:0] o_rd,
  output logic [31:0] o_rem,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_div_zero
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] rn, rm;       // latched operands, magnitudes after PREP
  logic        sgn;
  logic        neg_q, neg_r;
  // Partial remainder is always < |rm| < 2^32, so its top bit is never set
  // and only 32 bits are stored; the trial subtraction is still 33 bits wide.
  logic [31:0] rem;
  logic [31:0] q;
  logic [4:0]  cnt;
  logic [32:0] trial;
  logic        adv;

  // Datapath moves only when no flush or stall is pending; a flush never
  // touches the output registers.
  assign adv   = !i_clear_from_writeback && !i_data_stall && !i_clear_from_alu;
  assign trial = {rem, q[31]} - {1'b0, rm};

  assign o_valid = (state == S_DONE);
  assign o_busy  = (state == S_IDLE) ? i_start : (state != S_DONE);

  // State register with flush/stall priority.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                  state <= S_IDLE;
    else if (i_clear_from_writeback) state <= S_IDLE;
    else if (i_data_stall)           state <= state;
    else if (i_clear_from_alu)       state <= S_IDLE;
    else                             state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_PREP;
      S_PREP: state_nxt = (rm == 32'd0) ? S_DONE : S_CALC;
      S_CALC: if (cnt == 5'd0) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rn <= '0; rm <= '0; sgn <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
      rem <= '0; q <= '0; cnt <= '0;
      o_rd <= '0; o_rem <= '0; o_div_zero <= 1'b0;
    end else if (adv) begin
      case (state)
        S_IDLE: if (i_start) begin
          rn  <= i_rn;
          rm  <= i_rm;
          sgn <= i_signed;
        end
        S_PREP: begin
          neg_q <= sgn & (rn[31] ^ rm[31]);
          neg_r <= sgn & rn[31];
          rm    <= (sgn && rm[31]) ? -rm : rm;
          q     <= (sgn && rn[31]) ? -rn : rn;
          rem   <= '0;
          cnt   <= 5'd31;
          if (rm == 32'd0) begin
            o_rd       <= DIV_ZERO_VALUE;
            o_rem      <= rn;
            o_div_zero <= 1'b1;
          end
        end
        S_CALC: begin
          if (!trial[32]) begin
            rem <= trial[31:0];
            q   <= {q[30:0], 1'b1};
          end else begin
            rem <= {rem[30:0], q[31]};
            q   <= {q[30:0], 1'b0};
          end
          cnt <= cnt - 5'd1;
        end
        S_FIX: begin
          o_rd       <= neg_q ? -q : q;
          o_rem      <= neg_r ? -rem : rem;
          o_div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_shifter_divide.sv
// Directed bench for zap_shifter_divide: latency, results, stall, flushes and
// asynchronous reset.
module tb_zap_shifter_divide;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu;
  logic        i_start, i_signed;
  logic [31:0] i_rn, i_rm;
  logic [31:0] o_rd, o_rem;
  logic        o_busy, o_valid, o_div_zero;

  int total = 0;
  int bad   = 0;

  zap_shifter_divide #(.DIV_ZERO_VALUE(32'd0)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_clear_from_writeback(i_clear_from_writeback),
    .i_data_stall(i_data_stall), .i_clear_from_alu(i_clear_from_alu),
    .i_start(i_start), .i_signed(i_signed), .i_rn(i_rn), .i_rm(i_rm),
    .o_rd(o_rd), .o_rem(o_rem), .o_busy(o_busy), .o_valid(o_valid),
    .o_div_zero(o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drives the accept edge (cycle 0); returns #1 into cycle 1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge i_clk);
    i_rn = a; i_rm = b; i_signed = s; i_start = 1'b1;
    #1 chk("busy_c0", {31'd0, o_busy}, 32'd1);
    @(posedge i_clk); #1;
    i_start = 1'b0; i_rn = 32'hdeadbeef; i_rm = 32'h5; i_signed = ~s;
  endtask

  // Waits for o_valid, stalling cycles [st_at, st_at+st_len). Reports the
  // cycle o_valid appeared and whether o_busy stayed high before it.
  task automatic wait_valid(input int st_at, input int st_len, output int cyc,
                            output logic busy_ok);
    cyc = 1; busy_ok = 1'b1;
    while (!o_valid && cyc < 80) begin
      if (!o_busy) busy_ok = 1'b0;
      i_data_stall = (cyc >= st_at && cyc < st_at + st_len);
      @(posedge i_clk); #1;
      cyc++;
    end
    i_data_stall = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat, input int st_at, input int st_len);
    int   cyc;
    logic bok;
    start_op(a, b, s);
    wait_valid(st_at, st_len, cyc, bok);
    chk({tag, "_lat"},  cyc, elat);
    chk({tag, "_busy"}, {31'd0, bok}, 32'd1);
    chk({tag, "_q"},    o_rd, eq);
    chk({tag, "_r"},    o_rem, er);
    chk({tag, "_dz"},   {31'd0, o_div_zero}, {31'd0, edz});
    chk({tag, "_busy_done"}, {31'd0, o_busy}, 32'd0);
    @(posedge i_clk); #1;
    chk({tag, "_pulse"}, {31'd0, o_valid}, 32'd0);
  endtask

  // Starts a division, fires an abort during cycle 10, then checks that no
  // result appears and a fresh division still works.
  task automatic abort_test(input string tag, input int kind);
    logic seen;
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge i_clk); #1; end   // now in cycle 10
    if (kind == 0) i_clear_from_alu = 1'b1;
    else if (kind == 1) i_clear_from_writeback = 1'b1;
    else begin
      i_reset_n = 1'b0;
      #1;
      chk({tag, "_rd"},    o_rd, 32'd0);
      chk({tag, "_rem"},   o_rem, 32'd0);
      chk({tag, "_flags"}, {29'd0, o_busy, o_valid, o_div_zero}, 32'd0);
    end
    @(posedge i_clk); #1;
    i_clear_from_alu = 1'b0; i_clear_from_writeback = 1'b0; i_reset_n = 1'b1;
    chk({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (o_valid) seen = 1'b1;
      @(posedge i_clk); #1;
    end
    chk({tag, "_novalid"}, {31'd0, seen}, 32'd0);
    run_div({tag, "_after"}, 32'd50, 32'd6, 1'b0, 32'd8, 32'd2, 1'b0, 35, 0, 0);
  endtask

  initial begin
    int   cyc;
    logic bok;
    i_reset_n = 1'b0; i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;
    i_clear_from_alu = 1'b0; i_start = 1'b0; i_signed = 1'b0;
    i_rn = '0; i_rm = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_rd",    o_rd, 32'd0);
    chk("rst_rem",   o_rem, 32'd0);
    chk("rst_flags", {29'd0, o_busy, o_valid, o_div_zero}, 32'd0);
    i_reset_n = 1'b1;

    run_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 35, 0, 0);
    run_div("s_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 35, 0, 0);
    run_div("s_7_m2",   32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 35, 0, 0);
    run_div("u_ff_10",  32'hFFFFFFFF,   32'h10,         1'b0, 32'h0FFFFFFF,   32'hF,          1'b0, 35, 0, 0);
    run_div("s_min_m1", 32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 35, 0, 0);
    run_div("u_min_1",  32'h80000000,   32'd1,          1'b0, 32'h80000000,   32'd0,          1'b0, 35, 0, 0);
    run_div("u_small",  32'd3,          32'hFFFFFFFF,   1'b0, 32'd0,          32'd3,          1'b0, 35, 0, 0);
    run_div("div0",     32'h1234,       32'd0,          1'b0, 32'd0,          32'h1234,       1'b1, 2,  0, 0);
    run_div("stall",    32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 40, 10, 5);

    // Stall held over DONE keeps o_valid high for the stall length.
    start_op(32'd100, 32'd7, 1'b0);
    wait_valid(0, 0, cyc, bok);
    chk("dstall_lat", cyc, 35);
    i_data_stall = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("dstall_hold", {31'd0, o_valid}, 32'd1);
    end
    i_data_stall = 1'b0;
    @(posedge i_clk); #1;
    chk("dstall_end", {31'd0, o_valid}, 32'd0);
    chk("dstall_q", o_rd, 32'd14);

    abort_test("clr_alu", 0);
    abort_test("clr_wb",  1);
    abort_test("areset",  2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
